// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache (one 32-bit word per line) between IF and the memory fetch port.
// Latency: hit returns data 1 cycle after the lookup edge; miss returns 1 cycle after the memory ready pulse.
// Backpressure: if_ready_o only in IDLE; rdy=0 freezes every register; mem_req_o is a level held until ready.
//
// Ports:
//   clk, rst (sync, active-low), rdy (global hold)
//   if_req_i/if_pc_i/if_jump_i  : fetch request, address, redirect
//   flush_i                     : invalidate all lines
//   if_ready_o/if_inst_valid_o/if_inst_o : accept flag, one-cycle data pulse, instruction
//   mem_req_o/mem_addr_o/mem_inst_i/mem_inst_ready_i : word fetch handshake
module icache_direct #(
    parameter int INDEX_BITS = 7,
    localparam int TAG_BITS = 30 - INDEX_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req_i,
    input  logic [31:0] if_pc_i,
    input  logic        if_jump_i,
    input  logic        flush_i,
    output logic        if_ready_o,
    output logic        if_inst_valid_o,
    output logic [31:0] if_inst_o,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic [31:0] mem_inst_i,
    input  logic        mem_inst_ready_i
);

    localparam int LINES = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DROP  = 2'd2,
        S_RETRY = 2'd3
    } state_t;

    state_t state, state_n;

    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES];

    logic [31:0] pend_pc, pend_n;
    logic        fill_kill, kill_n;
    logic        inst_valid_n, req_n;
    logic [31:0] inst_n, addr_n;

    // Lookup: IDLE uses the live IF address, RETRY replays the redirect target.
    logic [31:0]           lk_pc;
    logic [INDEX_BITS-1:0] lk_idx;
    logic [TAG_BITS-1:0]   lk_tag;
    logic                  lk_en, lk_hit;

    assign lk_pc  = (state == S_RETRY) ? pend_pc : if_pc_i;
    assign lk_idx = lk_pc[INDEX_BITS+1:2];
    assign lk_tag = lk_pc[31:INDEX_BITS+2];
    assign lk_en  = ((state == S_IDLE) && (if_req_i || if_jump_i)) || (state == S_RETRY);
    // A lookup racing a flush must not hit on a line that is being invalidated.
    assign lk_hit = valid_q[lk_idx] && (tag_mem[lk_idx] == lk_tag) && !flush_i;

    // Fill target is always the outstanding request address.
    logic [INDEX_BITS-1:0] fill_idx;
    logic [TAG_BITS-1:0]   fill_tag;
    logic                  fill_done, fill_we;

    assign fill_idx  = mem_addr_o[INDEX_BITS+1:2];
    assign fill_tag  = mem_addr_o[31:INDEX_BITS+2];
    assign fill_done = ((state == S_FETCH) || (state == S_DROP)) && mem_inst_ready_i;
    // A flush seen at any point during the fetch makes the returning word stale.
    assign fill_we   = fill_done && !flush_i && !fill_kill;

    assign if_ready_o = (state == S_IDLE);

    logic unused_pc_bits;
    assign unused_pc_bits = ^lk_pc[1:0];

    always_comb begin
        state_n      = state;
        inst_valid_n = 1'b0;
        inst_n       = if_inst_o;
        req_n        = mem_req_o;
        addr_n       = mem_addr_o;
        pend_n       = pend_pc;
        kill_n       = fill_kill | flush_i;
        case (state)
            S_IDLE, S_RETRY: begin
                state_n = S_IDLE;
                if (lk_en) begin
                    if (lk_hit) begin
                        inst_n       = data_mem[lk_idx];
                        inst_valid_n = 1'b1;
                    end else begin
                        addr_n  = {lk_pc[31:2], 2'b00};
                        req_n   = 1'b1;
                        kill_n  = 1'b0;
                        state_n = S_FETCH;
                    end
                end
            end
            S_FETCH: begin
                if (mem_inst_ready_i) begin
                    req_n = 1'b0;
                    if (if_jump_i) begin
                        // Fill is kept in the array but the old address is no longer wanted.
                        pend_n  = if_pc_i;
                        state_n = S_RETRY;
                    end else begin
                        inst_n       = mem_inst_i;
                        inst_valid_n = 1'b1;
                        state_n      = S_IDLE;
                    end
                end else if (if_jump_i) begin
                    pend_n  = if_pc_i;
                    state_n = S_DROP;
                end
            end
            S_DROP: begin
                if (if_jump_i) begin
                    pend_n = if_pc_i;
                end
                if (mem_inst_ready_i) begin
                    req_n   = 1'b0;
                    state_n = S_RETRY;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state           <= S_IDLE;
            valid_q         <= '0;
            if_inst_valid_o <= 1'b0;
            if_inst_o       <= 32'd0;
            mem_req_o       <= 1'b0;
            mem_addr_o      <= 32'd0;
            pend_pc         <= 32'd0;
            fill_kill       <= 1'b0;
        end else if (rdy) begin
            state           <= state_n;
            if_inst_valid_o <= inst_valid_n;
            if_inst_o       <= inst_n;
            mem_req_o       <= req_n;
            mem_addr_o      <= addr_n;
            pend_pc         <= pend_n;
            fill_kill       <= kill_n;
            if (flush_i) begin
                valid_q <= '0;
            end else if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag/data need no reset: the valid bits gate every use.
    always_ff @(posedge clk) begin
        if (rst && rdy && fill_we) begin
            tag_mem[fill_idx]  <= fill_tag;
            data_mem[fill_idx] <= mem_inst_i;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Testbench for icache_direct: vector table, directed multi-cycle sequences, randomized transactions vs. a line model.
// Latency: checks hit = 1 cycle, miss = memory latency + 1 cycle.
// Backpressure: exercises rdy stalls during fetches and memory ready pulses that must be re-presented.
module tb_icache_direct;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b1;
    logic        if_req_i = 1'b0;
    logic [31:0] if_pc_i = 32'd0;
    logic        if_jump_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        if_ready_o;
    logic        if_inst_valid_o;
    logic [31:0] if_inst_o;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic [31:0] mem_inst_i;
    logic        mem_inst_ready_i;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory side: automatic responder or hand-driven pulses for exact-cycle sequences.
    int          mem_lat  = 5;
    bit          mem_auto = 1'b1;
    logic        auto_rdy = 1'b0;
    logic [31:0] auto_dat = 32'd0;
    logic        man_rdy  = 1'b0;
    logic [31:0] man_dat  = 32'd0;

    assign mem_inst_ready_i = mem_auto ? auto_rdy : man_rdy;
    assign mem_inst_i       = mem_auto ? auto_dat : man_dat;

    icache_direct dut (
        .clk              (clk),
        .rst              (rst),
        .rdy              (rdy),
        .if_req_i         (if_req_i),
        .if_pc_i          (if_pc_i),
        .if_jump_i        (if_jump_i),
        .flush_i          (flush_i),
        .if_ready_o       (if_ready_o),
        .if_inst_valid_o  (if_inst_valid_o),
        .if_inst_o        (if_inst_o),
        .mem_req_o        (mem_req_o),
        .mem_addr_o       (mem_addr_o),
        .mem_inst_i       (mem_inst_i),
        .mem_inst_ready_i (mem_inst_ready_i)
    );

    always #5 clk = ~clk;

    // Memory contents: odd multiplier keeps distinct word addresses distinct; address 0 holds 0x13.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a & 32'hFFFF_FFFC) * 32'h0100_0193 + 32'h0000_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Responder: after mem_lat cycles of mem_req_o, pulse ready once; repeats if the pulse was not taken.
    initial begin
        int cnt = 0;
        forever begin
            @(negedge clk);
            auto_rdy = 1'b0;
            if (mem_auto && rst && mem_req_o) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    auto_rdy = 1'b1;
                    auto_dat = mem_word(mem_addr_o);
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // One IF request held until the data pulse; observes whether memory was asked and for what.
    task automatic run_txn(input logic [31:0] pc, input bit do_flush, input bit rand_rdy,
                           output bit saw_req, output logic [31:0] req_addr,
                           output logic [31:0] data, output int lat, output bit got);
        saw_req = 1'b0; req_addr = 32'd0; data = 32'd0; lat = 0; got = 1'b0;
        if_req_i = 1'b1;
        if_pc_i  = pc;
        flush_i  = do_flush;
        for (int i = 0; i < 300 && !got; i++) begin
            @(negedge clk);
            flush_i = 1'b0;
            lat++;
            if (mem_req_o && !saw_req) begin
                saw_req  = 1'b1;
                req_addr = mem_addr_o;
            end
            if (if_inst_valid_o) begin
                got  = 1'b1;
                data = if_inst_o;
            end else if (rand_rdy && mem_req_o) begin
                rdy = ($urandom_range(0, 3) != 0);
            end else begin
                rdy = 1'b1;
            end
        end
        if_req_i = 1'b0;
        rdy      = 1'b1;
    endtask

    task automatic txn_check(input string name, input logic [31:0] pc, input bit do_flush,
                             input bit rand_rdy, input bit exp_miss, input logic [31:0] exp_data);
        bit          saw_req, got;
        logic [31:0] req_addr, data;
        int          lat;
        run_txn(pc, do_flush, rand_rdy, saw_req, req_addr, data, lat, got);
        check($sformatf("%s valid-before-timeout", name), {31'd0, got}, 32'd1);
        check($sformatf("%s data", name), data, exp_data);
        check($sformatf("%s mem_req", name), {31'd0, saw_req}, {31'd0, exp_miss});
        if (exp_miss) begin
            check($sformatf("%s mem_addr", name), req_addr, pc & 32'hFFFF_FFFC);
            if (!rand_rdy) check($sformatf("%s miss latency", name), lat, mem_lat + 1);
        end else begin
            check($sformatf("%s hit latency", name), lat, 32'd1);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          exp_miss;
        logic [31:0] exp_data;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
        $fatal(1);
    end

    initial begin
        vec_t vecs[8];
        int unsigned lines[int];

        vecs[0] = '{32'h0000_0000, 1'b1, 32'h0000_0013};
        vecs[1] = '{32'h0000_0000, 1'b0, 32'h0000_0013};
        vecs[2] = '{32'h0000_0004, 1'b1, mem_word(32'h4)};
        vecs[3] = '{32'h0000_0204, 1'b1, mem_word(32'h204)};
        vecs[4] = '{32'h0000_0006, 1'b1, mem_word(32'h4)};
        vecs[5] = '{32'h0000_0004, 1'b0, mem_word(32'h4)};
        vecs[6] = '{32'h0000_0040, 1'b1, mem_word(32'h40)};
        vecs[7] = '{32'h0000_0041, 1'b0, mem_word(32'h40)};

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b1;
        check("reset if_ready_o", {31'd0, if_ready_o}, 32'd1);
        check("reset if_inst_valid_o", {31'd0, if_inst_valid_o}, 32'd0);
        check("reset if_inst_o", if_inst_o, 32'd0);
        check("reset mem_req_o", {31'd0, mem_req_o}, 32'd0);
        check("reset mem_addr_o", mem_addr_o, 32'd0);

        // Cold miss, repeat hit, same-index conflict
        mem_lat = 5;
        for (int i = 0; i < 8; i++)
            txn_check($sformatf("vec%0d", i), vecs[i].pc, 1'b0, 1'b0, vecs[i].exp_miss, vecs[i].exp_data);

        // Jump during a miss: 0x100 never presented, 0x40 returned from RETRY
        mem_auto = 1'b0;
        if_req_i = 1'b1; if_pc_i = 32'h100;
        @(negedge clk);
        check("jmp mem_req", {31'd0, mem_req_o}, 32'd1);
        check("jmp mem_addr", mem_addr_o, 32'h100);
        @(negedge clk);
        check("jmp fetch not ready", {31'd0, if_ready_o}, 32'd0);
        if_req_i = 1'b0; if_jump_i = 1'b1; if_pc_i = 32'h40;
        @(negedge clk);
        if_jump_i = 1'b0;
        check("drop no valid", {31'd0, if_inst_valid_o}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("drop req held", {31'd0, mem_req_o}, 32'd1);
            check("drop addr stable", mem_addr_o, 32'h100);
            check("drop still no valid", {31'd0, if_inst_valid_o}, 32'd0);
        end
        man_rdy = 1'b1; man_dat = mem_word(32'h100);
        @(negedge clk);
        man_rdy = 1'b0;
        check("retry no valid", {31'd0, if_inst_valid_o}, 32'd0);
        check("retry req dropped", {31'd0, mem_req_o}, 32'd0);
        check("retry not ready", {31'd0, if_ready_o}, 32'd0);
        @(negedge clk);
        check("retry valid", {31'd0, if_inst_valid_o}, 32'd1);
        check("retry data", if_inst_o, mem_word(32'h40));
        mem_auto = 1'b1;
        txn_check("dropped fill kept", 32'h100, 1'b0, 1'b0, 1'b0, mem_word(32'h100));

        // Jump and ready in the same FETCH cycle
        mem_auto = 1'b0;
        if_req_i = 1'b1; if_pc_i = 32'h380;
        @(negedge clk);
        check("same mem_req", {31'd0, mem_req_o}, 32'd1);
        if_req_i = 1'b0; if_jump_i = 1'b1; if_pc_i = 32'h40;
        man_rdy = 1'b1; man_dat = mem_word(32'h380);
        @(negedge clk);
        if_jump_i = 1'b0; man_rdy = 1'b0;
        check("same no valid", {31'd0, if_inst_valid_o}, 32'd0);
        check("same req dropped", {31'd0, mem_req_o}, 32'd0);
        @(negedge clk);
        check("same retry valid", {31'd0, if_inst_valid_o}, 32'd1);
        check("same retry data", if_inst_o, mem_word(32'h40));
        mem_auto = 1'b1;
        txn_check("same fill kept", 32'h380, 1'b0, 1'b0, 1'b0, mem_word(32'h380));

        // Flush: three cached lines all miss afterwards; flush with a lookup forces a miss
        txn_check("pre-flush 0x4", 32'h4, 1'b0, 1'b0, 1'b0, mem_word(32'h4));
        txn_check("pre-flush 0x40", 32'h40, 1'b0, 1'b0, 1'b0, mem_word(32'h40));
        txn_check("pre-flush 0x380", 32'h380, 1'b0, 1'b0, 1'b0, mem_word(32'h380));
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        check("flush keeps ready", {31'd0, if_ready_o}, 32'd1);
        txn_check("post-flush 0x4", 32'h4, 1'b0, 1'b0, 1'b1, mem_word(32'h4));
        txn_check("post-flush 0x40", 32'h40, 1'b0, 1'b0, 1'b1, mem_word(32'h40));
        txn_check("post-flush 0x380", 32'h380, 1'b0, 1'b0, 1'b1, mem_word(32'h380));
        txn_check("flush+lookup 0x4", 32'h4, 1'b1, 1'b0, 1'b1, mem_word(32'h4));

        // rdy stall mid-FETCH: ready pulses while rdy=0 are not taken
        mem_auto = 1'b0;
        if_req_i = 1'b1; if_pc_i = 32'h600;
        @(negedge clk);
        check("stall mem_req", {31'd0, mem_req_o}, 32'd1);
        rdy = 1'b0;
        man_dat = mem_word(32'h600);
        for (int i = 0; i < 4; i++) begin
            man_rdy = (i % 2 == 1);
            @(negedge clk);
            check("stall req held", {31'd0, mem_req_o}, 32'd1);
            check("stall not ready", {31'd0, if_ready_o}, 32'd0);
            check("stall no valid", {31'd0, if_inst_valid_o}, 32'd0);
        end
        man_rdy = 1'b0; rdy = 1'b1;
        @(negedge clk);
        check("unstall still waiting", {31'd0, if_inst_valid_o}, 32'd0);
        check("unstall req held", {31'd0, mem_req_o}, 32'd1);
        man_rdy = 1'b1;
        @(negedge clk);
        man_rdy = 1'b0; if_req_i = 1'b0;
        check("stall fill valid", {31'd0, if_inst_valid_o}, 32'd1);
        check("stall fill data", if_inst_o, mem_word(32'h600));
        check("stall fill req low", {31'd0, mem_req_o}, 32'd0);

        // Flush during FETCH: word returned but line left invalid
        if_req_i = 1'b1; if_pc_i = 32'h700;
        @(negedge clk);
        check("kill mem_req", {31'd0, mem_req_o}, 32'd1);
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        @(negedge clk);
        man_rdy = 1'b1; man_dat = mem_word(32'h700);
        @(negedge clk);
        man_rdy = 1'b0; if_req_i = 1'b0;
        check("kill fill valid", {31'd0, if_inst_valid_o}, 32'd1);
        check("kill fill data", if_inst_o, mem_word(32'h700));
        mem_auto = 1'b1;
        txn_check("killed line misses", 32'h700, 1'b0, 1'b0, 1'b1, mem_word(32'h700));

        // Randomized transactions against a line-address model
        flush_i = 1'b1;
        @(negedge clk);
        flush_i = 1'b0;
        lines.delete();
        for (int t = 0; t < 80; t++) begin
            logic [31:0] pc;
            bit          do_flush, exp_miss;
            int          idx;
            int unsigned word;
            pc = ($urandom_range(0, 2) << 9) | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
            do_flush = ($urandom_range(0, 9) == 0);
            if (do_flush) lines.delete();
            word = pc >> 2;
            idx  = int'(word % 128);
            exp_miss = !(lines.exists(idx) && lines[idx] == word);
            mem_lat = $urandom_range(1, 6);
            txn_check($sformatf("rand%0d pc=%h", t, pc), pc, do_flush, 1'b1, exp_miss, mem_word(pc));
            lines[idx] = word;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/icache_direct.md
# icache_direct

Direct-mapped, read-only instruction cache between the PC/IF stage and the memory controller's instruction-fetch port. Hits return an instruction one cycle after the request. Misses issue a word fetch to the memory controller, fill the line, then return the word. A pending fetch can be redirected by a jump without corrupting the array.

## Interface
- INDEX_BITS, 7: line index width; 2^INDEX_BITS one-word lines.
- TAG_BITS, 30-INDEX_BITS: tag width (derived; not overridden).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- rdy  in  1  global ready; when 0 all state and outputs hold.
- if_req_i  in  1  IF requests the instruction at if_pc_i.
- if_pc_i  in  32  fetch address; bits [1:0] ignored.
- if_jump_i  in  1  redirect; if_pc_i carries the jump target this cycle.
- flush_i  in  1  invalidate all lines (fence.i).
- if_ready_o  out  1  cache can accept a request this cycle.
- if_inst_valid_o  out  1  one-cycle pulse: if_inst_o is valid.
- if_inst_o  out  32  returned instruction.
- mem_req_o  out  1  level request to the memory controller.
- mem_addr_o  out  32  word-aligned fetch address.
- mem_inst_i  in  32  fetched word.
- mem_inst_ready_i  in  1  one-cycle pulse: mem_inst_i is valid.

## Operation
- Address split: index = pc[INDEX_BITS+1:2]; tag = pc[31:INDEX_BITS+2].
- Storage per line: valid bit, TAG_BITS tag, 32-bit data.
- States:
  - IDLE: if_ready_o=1. When if_req_i or if_jump_i is high, look up if_pc_i.
    - Hit: if_inst_o <= data; if_inst_valid_o <= 1; stay in IDLE.
    - Miss: latch the address; mem_addr_o <= {pc[31:2],2'b00}; mem_req_o <= 1; go to FETCH.
  - FETCH: if_ready_o=0.
    - On mem_inst_ready_i: write the line (valid=1, tag, data); if_inst_o <= mem_inst_i; if_inst_valid_o <= 1; mem_req_o <= 0; go to IDLE.
    - On if_jump_i without mem_inst_ready_i: latch the target into pend_pc; go to DROP.
  - DROP: if_ready_o=0; mem_req_o stays 1 until mem_inst_ready_i.
    - On mem_inst_ready_i: write the fill to the array (the data is valid for the old address) but do not present it; mem_req_o <= 0; go to RETRY.
    - Another if_jump_i while in DROP overwrites pend_pc.
  - RETRY: one cycle. Look up pend_pc exactly as IDLE does (hit returns it; miss goes to FETCH).
- If if_jump_i and mem_inst_ready_i occur in the same FETCH cycle, the fill is written and not presented. pend_pc <= target; go to RETRY.
- A request in IDLE with both if_req_i and if_jump_i high uses if_pc_i once.
- if_req_i outside IDLE/RETRY is ignored. IF holds if_req_i and if_pc_i until if_inst_valid_o.
- flush_i clears every valid bit at the next edge, in any state.
  - An in-flight fill still completes its handshake but is not written.
  - A lookup in the same cycle as flush_i treats the access as a miss.
- rdy=0: no state, array, or output register changes. Handshake inputs are not sampled.

## Timing
- Reset (rst=0 at an edge): state=IDLE; all valid bits=0; if_inst_valid_o=0; if_inst_o=0; mem_req_o=0; mem_addr_o=0; pend_pc=0. if_ready_o=1 after reset.
- Reset asserted mid-FETCH abandons the fill. The memory controller is reset by the same rst.
- Hit latency: request at edge N, if_inst_valid_o high during cycle N+1.
- Miss latency: mem_req_o high from cycle N+1. Data is returned one cycle after the mem_inst_ready_i edge M, so if_inst_valid_o is high in cycle M+1.
- Jump recovery after DROP: RETRY occupies one cycle. Data appears one cycle after RETRY on a hit.
- mem_addr_o is stable while mem_req_o=1.
- if_ready_o is combinational from state (IDLE only).

## Test plan
- Cold miss: after reset, request pc=0x00000000; memory returns 0x00000013 after 5 cycles. Expect mem_req_o with mem_addr_o=0, then if_inst_valid_o, if_inst_o=0x00000013. A repeat request hits in 1 cycle with no mem_req_o.
- Conflict: with INDEX_BITS=7, fill 0x0000_0004 and then 0x0000_0204 (same index). Re-requesting 0x4 misses again and returns the original word.
- Jump during miss: request 0x100 (miss); 2 cycles later if_jump_i with target 0x40 (cached). No if_inst_valid_o for 0x100. After mem_inst_ready_i, RETRY returns the 0x40 word. A later 0x100 request hits.
- Same-cycle jump and ready: if_inst_valid_o is not asserted for the old address. The next valid carries the target's instruction.
- flush_i: fill 3 lines, pulse flush_i, re-request all 3. Each issues mem_req_o. A flush during FETCH leaves that line invalid.
- rdy stall: deassert rdy for 4 cycles mid-FETCH while memory pulses ready. Expect no state change and the fill completing only after rdy=1 with a re-presented ready.
